// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer synchronisers (both directions).
package async_fifo_pkg;

    // Legal depth range of a synchroniser flop chain.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Widest pointer the conversion helpers accept; narrower pointers are zero-extended.
    localparam int GRAY_W_MAX = 32;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extended upper bits contribute nothing, so callers may truncate the result.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] gray);
        logic [GRAY_W_MAX-1:0] bin;
        bin[GRAY_W_MAX-1] = gray[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Binary to Gray, used by the pointer registers that feed a synchroniser.
    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_chain_n.sv
// Generic N-flop synchroniser chain with asynchronous active-high reset.
// Stage 0 samples the asynchronous input; q is the last stage.
module sync_chain_n
    import async_fifo_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("sync_chain_n: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the sampled value one flop further down the chain on every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/rptr_sync_wdomain.sv
// Write-side read-pointer synchroniser: brings the Gray read pointer into w_clk,
// converts it to binary and derives fill level, full/almost-full, a post-reset
// valid qualifier and a sticky pointer-consistency error.
module rptr_sync_wdomain
    import async_fifo_pkg::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 12
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic [ADDR_BITS:0] r_ptr_gray,
    input  logic [ADDR_BITS:0] w_ptr_bin,
    input  logic               err_clr,
    output logic [ADDR_BITS:0] r_ptr_sync,
    output logic [ADDR_BITS:0] r_ptr_bin,
    output logic [ADDR_BITS:0] w_level,
    output logic               w_full,
    output logic               w_almost_full,
    output logic               sync_valid,
    output logic               ptr_err
);

    localparam int PTR_W = ADDR_BITS + 1;
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);

    localparam logic [PTR_W-1:0] DEPTH_L     = PTR_W'(1 << ADDR_BITS);
    localparam logic [PTR_W-1:0] AF_THRESH_L = PTR_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] VALID_TERM  = CNT_W'(SYNC_STAGES + 1);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("rptr_sync_wdomain: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
        end
        if (AF_THRESH < 1 || AF_THRESH > (1 << ADDR_BITS)) begin : g_bad_thresh
            $error("rptr_sync_wdomain: AF_THRESH=%0d outside 1..%0d", AF_THRESH, 1 << ADDR_BITS);
        end
    endgenerate

    logic [CNT_W-1:0] valid_cnt_r;
    logic [PTR_W-1:0] level_s;
    logic             full_s;
    logic             almost_full_s;
    logic             over_s;

    sync_chain_n #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (w_clk),
        .rst (w_rst),
        .d   (r_ptr_gray),
        .q   (r_ptr_sync)
    );

    // Convert the synchronised Gray pointer to binary in its own register stage.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_ptr_bin <= {PTR_W{1'b0}};
        end else begin
            r_ptr_bin <= PTR_W'(gray2bin(GRAY_W_MAX'(r_ptr_sync)));
        end
    end

    // Count edges since reset release until the whole chain plus converter has flushed.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            valid_cnt_r <= {CNT_W{1'b0}};
        end else if (valid_cnt_r != VALID_TERM) begin
            valid_cnt_r <= valid_cnt_r + CNT_W'(1);
        end else begin
            valid_cnt_r <= valid_cnt_r;
        end
    end

    assign sync_valid = (valid_cnt_r == VALID_TERM);

    // Fill level and flags; until the pipeline is flushed the flags block writes.
    always_comb begin
        level_s       = w_ptr_bin - r_ptr_bin;
        full_s        = 1'b1;
        almost_full_s = 1'b1;
        over_s        = (level_s > DEPTH_L);
        if (sync_valid) begin
            full_s        = (level_s == DEPTH_L);
            almost_full_s = (level_s >= AF_THRESH_L);
        end else begin
            full_s        = 1'b1;
            almost_full_s = 1'b1;
        end
    end

    assign w_level       = level_s;
    assign w_full        = full_s;
    assign w_almost_full = almost_full_s;

    // Sticky error: an impossible level sets it; err_clr clears it unless a set coincides.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            ptr_err <= 1'b0;
        end else if (over_s) begin
            ptr_err <= 1'b1;
        end else if (err_clr) begin
            ptr_err <= 1'b0;
        end else begin
            ptr_err <= ptr_err;
        end
    end

endmodule

// File: tb/tb_rptr_sync_wdomain.sv
// Self-checking bench for rptr_sync_wdomain: directed scenarios plus randomized
// stimulus compared against an edge-history reference model.
module tb_rptr_sync_wdomain;

    logic       w_clk = 1'b0;
    logic       w_rst = 1'b0;
    logic [4:0] r_ptr_gray = 5'd0;
    logic [4:0] w_ptr_bin  = 5'd0;
    logic       err_clr    = 1'b0;

    logic [4:0] sync2, bin2, lvl2;
    logic       full2, af2, valid2, err2;
    logic [4:0] sync3, bin3, lvl3;
    logic       full3, af3, valid3, err3;
    logic [4:0] sync4, bin4, lvl4;
    logic       full4, af4, valid4, err4;

    int vec  = 0;
    int miss = 0;

    always #5 w_clk = ~w_clk;

    rptr_sync_wdomain #(.ADDR_BITS(4), .SYNC_STAGES(2), .AF_THRESH(12)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .r_ptr_gray(r_ptr_gray), .w_ptr_bin(w_ptr_bin),
        .err_clr(err_clr), .r_ptr_sync(sync2), .r_ptr_bin(bin2), .w_level(lvl2),
        .w_full(full2), .w_almost_full(af2), .sync_valid(valid2), .ptr_err(err2));

    rptr_sync_wdomain #(.ADDR_BITS(4), .SYNC_STAGES(3), .AF_THRESH(12)) dut3 (
        .w_clk(w_clk), .w_rst(w_rst), .r_ptr_gray(r_ptr_gray), .w_ptr_bin(w_ptr_bin),
        .err_clr(err_clr), .r_ptr_sync(sync3), .r_ptr_bin(bin3), .w_level(lvl3),
        .w_full(full3), .w_almost_full(af3), .sync_valid(valid3), .ptr_err(err3));

    rptr_sync_wdomain #(.ADDR_BITS(4), .SYNC_STAGES(4), .AF_THRESH(12)) dut4 (
        .w_clk(w_clk), .w_rst(w_rst), .r_ptr_gray(r_ptr_gray), .w_ptr_bin(w_ptr_bin),
        .err_clr(err_clr), .r_ptr_sync(sync4), .r_ptr_bin(bin4), .w_level(lvl4),
        .w_full(full4), .w_almost_full(af4), .sync_valid(valid4), .ptr_err(err4));

    // ---------------- reference model ----------------
    // samp[n] is the Gray value seen at the n-th edge after reset release.
    int         edge_cnt = 0;
    logic [4:0] samp [64];
    logic       err_m = 1'b0;

    // Decode Gray by searching for the binary value whose Gray code matches.
    function automatic logic [4:0] g2b(input logic [4:0] g);
        for (int b = 0; b < 32; b++) begin
            if (5'(b ^ (b >> 1)) == g) return 5'(b);
        end
        return 5'd0;
    endfunction

    function automatic logic [4:0] exp_sync(input int s);
        return (edge_cnt >= s) ? samp[(edge_cnt - s + 1) % 64] : 5'd0;
    endfunction

    function automatic logic [4:0] exp_bin(input int s);
        return (edge_cnt >= s + 1) ? g2b(samp[(edge_cnt - s) % 64]) : 5'd0;
    endfunction

    function automatic logic [4:0] exp_level();
        return 5'(w_ptr_bin - exp_bin(2));
    endfunction

    function automatic logic exp_valid();
        return edge_cnt >= 3;
    endfunction

    always @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            edge_cnt <= 0;
            err_m    <= 1'b0;
        end else begin
            if (5'(w_ptr_bin - exp_bin(2)) > 5'd16) err_m <= 1'b1;
            else if (err_clr)                       err_m <= 1'b0;
            samp[(edge_cnt + 1) % 64] <= r_ptr_gray;
            edge_cnt <= edge_cnt + 1;
        end
    end

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        r_ptr_gray = 5'b00110;
        w_ptr_bin  = 5'd7;
        #1 w_rst = 1'b1;
        step();
        step();
        vec++; if (sync2 !== 5'd0) begin miss++; $display("FAIL reset_sync got=%0d exp=0", sync2); end
        vec++; if (bin2 !== 5'd0) begin miss++; $display("FAIL reset_bin got=%0d exp=0", bin2); end
        vec++; if (lvl2 !== 5'd7) begin miss++; $display("FAIL reset_level got=%0d exp=7", lvl2); end
        vec++; if (full2 !== 1'b1 || af2 !== 1'b1) begin miss++; $display("FAIL reset_flags full=%b af=%b exp=1/1", full2, af2); end
        vec++; if (valid2 !== 1'b0 || err2 !== 1'b0) begin miss++; $display("FAIL reset_valid_err valid=%b err=%b exp=0/0", valid2, err2); end
        r_ptr_gray = 5'd0;
        w_rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            vec++;
            if (valid2 !== 1'(k >= 3)) begin miss++; $display("FAIL release_valid edge=%0d got=%b exp=%b", k, valid2, k >= 3); end
        end
    endtask

    task automatic test_latency();
        r_ptr_gray = 5'b00001;
        for (int k = 1; k <= 6; k++) begin
            step();
            vec++; if (sync2 !== ((k >= 2) ? 5'd1 : 5'd0) || bin2 !== ((k >= 3) ? 5'd1 : 5'd0)) begin
                miss++; $display("FAIL latency_s2 edge=%0d sync=%0d bin=%0d", k, sync2, bin2); end
            vec++; if (sync3 !== ((k >= 3) ? 5'd1 : 5'd0) || bin3 !== ((k >= 4) ? 5'd1 : 5'd0)) begin
                miss++; $display("FAIL latency_s3 edge=%0d sync=%0d bin=%0d", k, sync3, bin3); end
            vec++; if (sync4 !== ((k >= 4) ? 5'd1 : 5'd0) || bin4 !== ((k >= 5) ? 5'd1 : 5'd0)) begin
                miss++; $display("FAIL latency_s4 edge=%0d sync=%0d bin=%0d", k, sync4, bin4); end
        end
    endtask

    task automatic test_flags();
        r_ptr_gray = 5'd0;
        for (int k = 0; k < 4; k++) step();
        w_ptr_bin = 5'd16; #1;
        vec++; if (lvl2 !== 5'd16 || full2 !== 1'b1) begin miss++; $display("FAIL flags_16 level=%0d full=%b exp=16/1", lvl2, full2); end
        w_ptr_bin = 5'd15; #1;
        vec++; if (full2 !== 1'b0 || af2 !== 1'b1) begin miss++; $display("FAIL flags_15 full=%b af=%b exp=0/1", full2, af2); end
        w_ptr_bin = 5'd12; #1;
        vec++; if (full2 !== 1'b0 || af2 !== 1'b1) begin miss++; $display("FAIL flags_12 full=%b af=%b exp=0/1", full2, af2); end
        w_ptr_bin = 5'd11; #1;
        vec++; if (full2 !== 1'b0 || af2 !== 1'b0) begin miss++; $display("FAIL flags_11 full=%b af=%b exp=0/0", full2, af2); end
    endtask

    task automatic test_wrap();
        w_ptr_bin  = 5'd3;
        r_ptr_gray = 5'b10001;
        for (int k = 0; k < 4; k++) step();
        vec++; if (bin2 !== 5'd30) begin miss++; $display("FAIL wrap_bin got=%0d exp=30", bin2); end
        vec++; if (lvl2 !== 5'd5 || full2 !== 1'b0) begin miss++; $display("FAIL wrap_5 level=%0d full=%b exp=5/0", lvl2, full2); end
        w_ptr_bin = 5'd14; #1;
        vec++; if (lvl2 !== 5'd16 || full2 !== 1'b1) begin miss++; $display("FAIL wrap_16 level=%0d full=%b exp=16/1", lvl2, full2); end
    endtask

    task automatic test_error();
        w_ptr_bin  = 5'd3;
        r_ptr_gray = 5'd0;
        for (int k = 0; k < 4; k++) step();
        vec++; if (err2 !== 1'b0) begin miss++; $display("FAIL err_idle got=%b exp=0", err2); end
        w_ptr_bin = 5'd20; #1;
        vec++; if (lvl2 !== 5'd20) begin miss++; $display("FAIL err_level got=%0d exp=20", lvl2); end
        step();
        vec++; if (err2 !== 1'b1) begin miss++; $display("FAIL err_set got=%b exp=1", err2); end
        w_ptr_bin = 5'd5;
        step();
        vec++; if (err2 !== 1'b1) begin miss++; $display("FAIL err_sticky got=%b exp=1", err2); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vec++; if (err2 !== 1'b0) begin miss++; $display("FAIL err_clear got=%b exp=0", err2); end
        w_ptr_bin = 5'd20;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        vec++; if (err2 !== 1'b1) begin miss++; $display("FAIL err_set_wins got=%b exp=1", err2); end
    endtask

    task automatic test_mid_reset();
        r_ptr_gray = 5'b00011;
        w_ptr_bin  = 5'd11;
        for (int k = 0; k < 4; k++) step();
        vec++; if (lvl2 !== 5'd9 || err2 !== 1'b1) begin miss++; $display("FAIL midrst_pre level=%0d err=%b exp=9/1", lvl2, err2); end
        #2 w_rst = 1'b1;
        #1;
        vec++; if (sync2 !== 5'd0 || bin2 !== 5'd0 || lvl2 !== 5'd11) begin
            miss++; $display("FAIL midrst_ptrs sync=%0d bin=%0d level=%0d exp=0/0/11", sync2, bin2, lvl2); end
        vec++; if (err2 !== 1'b0 || valid2 !== 1'b0 || full2 !== 1'b1 || af2 !== 1'b1) begin
            miss++; $display("FAIL midrst_flags err=%b valid=%b full=%b af=%b exp=0/0/1/1", err2, valid2, full2, af2); end
        @(negedge w_clk);
        w_rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            vec++; if (valid2 !== 1'(k >= 3) || full2 !== 1'(k < 3)) begin
                miss++; $display("FAIL midrst_release edge=%0d valid=%b full=%b", k, valid2, full2); end
        end
        vec++; if (lvl2 !== 5'd9) begin miss++; $display("FAIL midrst_level got=%0d exp=9", lvl2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step();
            r_ptr_gray = 5'($urandom_range(0, 31));
            w_ptr_bin  = 5'($urandom_range(0, 31));
            err_clr    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) begin
                w_rst = 1'b1;
                #1 w_rst = 1'b0;
            end
            #1;
            vec++; if (sync2 !== exp_sync(2) || bin2 !== exp_bin(2)) begin
                miss++; $display("FAIL rnd_ptr2 n=%0d sync=%0d/%0d bin=%0d/%0d", n, sync2, exp_sync(2), bin2, exp_bin(2)); end
            vec++; if (sync3 !== exp_sync(3) || bin3 !== exp_bin(3) || sync4 !== exp_sync(4) || bin4 !== exp_bin(4)) begin
                miss++; $display("FAIL rnd_ptr34 n=%0d s3=%0d/%0d b3=%0d/%0d s4=%0d/%0d b4=%0d/%0d", n,
                                 sync3, exp_sync(3), bin3, exp_bin(3), sync4, exp_sync(4), bin4, exp_bin(4)); end
            vec++; if (lvl2 !== exp_level() || valid2 !== exp_valid()) begin
                miss++; $display("FAIL rnd_level n=%0d level=%0d/%0d valid=%b/%b", n, lvl2, exp_level(), valid2, exp_valid()); end
            vec++; if (full2 !== (!exp_valid() || exp_level() == 5'd16) || af2 !== (!exp_valid() || exp_level() >= 5'd12)) begin
                miss++; $display("FAIL rnd_flags n=%0d full=%b af=%b level=%0d valid=%b", n, full2, af2, exp_level(), exp_valid()); end
            vec++; if (err2 !== err_m) begin
                miss++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err2, err_m); end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_flags();
        test_wrap();
        test_error();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
